conv1_input_streamer: RTL and testbench
=======================================

CONV1_INPUT_STREAMER -- requirements
Module: conv1_input_streamer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  pDATA_WIDTH, 8, bits per channel sample
  pIN_CHANNEL, 3, channels packed per pixel word
  pINPUT_WIDTH, 224, pixels per row
  pINPUT_HEIGHT, 224, rows per frame
  pBASE_ADDR, 0, first valid load address
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous active-high reset
  load_en  in  1  host pixel write strobe
  load_addr  in  32  host pixel address
  load_data  in  pDATA_WIDTH*pIN_CHANNEL  host pixel word
  start  in  1  begin streaming one frame
  rd_en  in  1  consumer read request, one pixel per asserted cycle
  conv_en  out  1  enable to consumer, high while streaming
  data_valid  out  1  data_out holds a pixel this cycle
  data_out  out  pDATA_WIDTH*pIN_CHANNEL  pixel word, raster order, channel 0 in LSBs
  busy  out  1  frame in progress
  frame_done  out  1  one-cycle pulse after last pixel delivered
REQ-003 Clocking and reset SHALL be one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 Frame store SHALL hold NPIX = pINPUT_WIDTH*pINPUT_HEIGHT words; write index = load_addr - pBASE_ADDR.
REQ-005 load_en SHALL write only in IDLE with pBASE_ADDR <= load_addr < pBASE_ADDR+NPIX; other writes are silently dropped.
REQ-006 FSM states SHALL be IDLE, STREAM, DONE.
REQ-007 IDLE->STREAM on start; start in STREAM or DONE is ignored.
REQ-008 In STREAM, conv_en=1 and busy=1; in IDLE both are 0; in DONE, conv_en=0 and busy=1.
REQ-009 Each cycle in STREAM with rd_en=1 and rd_ptr<NPIX SHALL read word rd_ptr and increment rd_ptr.
REQ-010 Read latency SHALL be exactly 1 cycle: data_valid=1 and data_out=word in the cycle after the accepted rd_en.
REQ-011 Back-to-back rd_en SHALL yield back-to-back data_valid at one pixel per cycle with no bubbles.
REQ-012 rd_en in IDLE or DONE, or with rd_ptr=NPIX, SHALL be ignored: no read, no pointer change, data_valid=0 the next cycle.
REQ-013 STREAM->DONE SHALL occur in the cycle in which the pixel at index NPIX-1 is presented with data_valid=1.
REQ-014 DONE SHALL last one cycle with frame_done=1, then go to IDLE with rd_ptr cleared to 0.
REQ-015 data_out SHALL hold its last value when data_valid=0, so that a zero mux downstream is the only padding source.
REQ-016 start and load_en together in IDLE SHALL both take effect; the write completes before the first read.
REQ-017 rd_ptr SHALL be $clog2(NPIX+1) bits wide and never wrap.

Reset
REQ-018 On rst: state=IDLE, rd_ptr=0, conv_en=0, busy=0, data_valid=0, frame_done=0, data_out=0.
REQ-019 rst mid-frame SHALL abort the frame immediately with no frame_done pulse; frame store contents are retained.

Structure
REQ-020 A shared package SHALL hold the FSM state enum (IDLE, STREAM, DONE) and the NPIX and pointer-width helper functions.
REQ-021 The frame store SHALL be one sub-module, conv1_frame_ram (1 write port, 1 registered read port); the FSM and pointer SHALL live in the top.

Verification (pINPUT_WIDTH=4, pINPUT_HEIGHT=4, pBASE_ADDR=0x100)
REQ-022 Load words 0x000000..0x00000F at 0x100..0x10F, start, hold rd_en for 16 cycles -> 16 consecutive data_valid with values 0x00..0x0F, frame_done one cycle after the last, busy falls the next cycle.
REQ-023 rd_en toggled 1,0,1,0 -> data_valid follows the pattern delayed by one cycle; data_out is unchanged on invalid cycles.
REQ-024 Write to 0x0FF and 0x110, and a write to 0x100 during STREAM -> store unchanged; next frame reads the original values.
REQ-025 rd_en held high for 20 cycles -> exactly 16 data_valid; extra requests are ignored; a second start after IDLE replays from pixel 0.
REQ-026 rst asserted after 7 pixels -> all outputs 0 the next cycle with no frame_done; a new start streams from pixel 0 with the data intact.

Source files
------------

// File: rtl/conv1_input_streamer_pkg.sv
// ---------------------------------------------------------------------------
// conv1_input_streamer_pkg
// Shared types and sizing helpers for the conv1 input streamer.
//   state_t         : streamer FSM state encoding (IDLE, STREAM, DONE)
//   f_npix          : pixels per frame
//   f_ptr_width     : read pointer width, wide enough to hold NPIX itself
//   f_addr_width    : frame store address width (at least 1 bit)
// ---------------------------------------------------------------------------
package conv1_input_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic int f_npix(input int width, input int height);
        return width * height;
    endfunction

    // The pointer must be able to sit at NPIX (frame exhausted) without wrapping.
    function automatic int f_ptr_width(input int npix);
        return $clog2(npix + 1);
    endfunction

    function automatic int f_addr_width(input int npix);
        return (npix > 1) ? $clog2(npix) : 1;
    endfunction

endpackage

// File: rtl/conv1_frame_ram.sv
// ---------------------------------------------------------------------------
// conv1_frame_ram
// Single-frame pixel store: one write port, one registered read port.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (clears the read register only)
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_en    : read strobe; o_rd_data updates on the following edge
//   i_rd_addr  : read address
//   o_rd_data  : registered read data, held while i_rd_en is low
// ---------------------------------------------------------------------------
module conv1_frame_ram #(
    parameter int pWIDTH  = 24,
    parameter int pDEPTH  = 16,
    parameter int pADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wr_en,
    input  logic [pADDR_W-1:0] i_wr_addr,
    input  logic [pWIDTH-1:0]  i_wr_data,
    input  logic               i_rd_en,
    input  logic [pADDR_W-1:0] i_rd_addr,
    output logic [pWIDTH-1:0]  o_rd_data
);

    logic [pWIDTH-1:0] r_mem [pDEPTH];
    logic [pWIDTH-1:0] r_rd_data;

    // Storage is deliberately not reset so a frame survives a mid-frame abort.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/conv1_input_streamer.sv
// ---------------------------------------------------------------------------
// conv1_input_streamer
// Holds one input frame loaded by the host and streams it to the conv1
// consumer in raster order, one pixel per accepted read request.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   load_en     : host pixel write strobe (honoured in IDLE only)
//   load_addr   : host pixel address, pBASE_ADDR-relative window of NPIX words
//   load_data   : host pixel word, channel 0 in LSBs
//   start       : begin streaming one frame (honoured in IDLE only)
//   rd_en       : consumer read request
//   conv_en     : high while streaming
//   data_valid  : data_out carries a pixel this cycle (1 cycle after rd_en)
//   data_out    : pixel word, held when data_valid is low
//   busy        : frame in progress (STREAM or DONE)
//   frame_done  : one-cycle pulse after the last pixel is delivered
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | host may load the store; waiting for start
// STREAM | serving reads; leaves once pixel NPIX-1 is on data_out
// DONE   | single cycle, frame_done pulse, pointer cleared
// ---------------------------------------------------------------------------
module conv1_input_streamer
    import conv1_input_streamer_pkg::*;
#(
    parameter int pDATA_WIDTH   = 8,
    parameter int pIN_CHANNEL   = 3,
    parameter int pINPUT_WIDTH  = 224,
    parameter int pINPUT_HEIGHT = 224,
    parameter int pBASE_ADDR    = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load_en,
    input  logic [31:0]                          load_addr,
    input  logic [pDATA_WIDTH*pIN_CHANNEL-1:0]   load_data,
    input  logic                                 start,
    input  logic                                 rd_en,
    output logic                                 conv_en,
    output logic                                 data_valid,
    output logic [pDATA_WIDTH*pIN_CHANNEL-1:0]   data_out,
    output logic                                 busy,
    output logic                                 frame_done
);

    localparam int NPIX   = f_npix(pINPUT_WIDTH, pINPUT_HEIGHT);
    localparam int PTR_W  = f_ptr_width(NPIX);
    localparam int ADDR_W = f_addr_width(NPIX);
    localparam int DW     = pDATA_WIDTH * pIN_CHANNEL;

    state_t             r_state;
    state_t             w_next_state;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic               r_data_valid;
    logic [31:0]        w_wr_offset;
    logic               w_wr_accept;
    logic               w_rd_accept;
    logic               w_last_shown;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [DW-1:0]      w_rd_data;

    // Offset compare catches both below-base (wraps huge) and past-end addresses.
    assign w_wr_offset = load_addr - 32'(pBASE_ADDR);
    assign w_wr_accept = (r_state == IDLE) && load_en
                         && (load_addr >= 32'(pBASE_ADDR))
                         && (w_wr_offset < 32'(NPIX));
    assign w_wr_addr   = w_wr_offset[ADDR_W-1:0];

    assign w_rd_accept = (r_state == STREAM) && rd_en && (r_rd_ptr < PTR_W'(NPIX));
    assign w_rd_addr   = r_rd_ptr[ADDR_W-1:0];

    // The pointer only reaches NPIX after the final read, so a valid pixel
    // with the pointer at NPIX is pixel NPIX-1 on data_out.
    assign w_last_shown = r_data_valid && (r_rd_ptr == PTR_W'(NPIX));

    conv1_frame_ram #(
        .pWIDTH  (DW),
        .pDEPTH  (NPIX),
        .pADDR_W (ADDR_W)
    ) u_frame_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (load_data),
        .i_rd_en   (w_rd_accept),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = STREAM;
            STREAM:  if (w_last_shown) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        conv_en    = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            STREAM: begin
                conv_en = 1'b1;
                busy    = 1'b1;
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_accept;
            if (r_state == DONE) begin
                r_rd_ptr <= '0;
            end else if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    assign data_valid = r_data_valid;
    assign data_out   = w_rd_data;

endmodule

// File: tb/tb_conv1_input_streamer.sv
module tb_conv1_input_streamer;

    localparam int          W    = 4;
    localparam int          H    = 4;
    localparam int          NPIX = W * H;
    localparam int          DW   = 24;
    localparam logic [31:0] BASE = 32'h100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic [31:0]   load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          start = 1'b0;
    logic          rd_en = 1'b0;
    logic          conv_en, data_valid, busy, frame_done;
    logic [DW-1:0] data_out;

    always #5 clk = ~clk;

    conv1_input_streamer #(
        .pDATA_WIDTH   (8),
        .pIN_CHANNEL   (3),
        .pINPUT_WIDTH  (W),
        .pINPUT_HEIGHT (H),
        .pBASE_ADDR    (32'h100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .rd_en      (rd_en),
        .conv_en    (conv_en),
        .data_valid (data_valid),
        .data_out   (data_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the streamer plus the expected-pixel scoreboard.
    logic [DW-1:0] mem_model [NPIX];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_exp = '0;
    bit            m_streaming = 0;
    bit            m_in_done = 0;
    bit            m_fd_pending = 0;
    bit            m_pushed = 0;
    bit            m_pushed_last = 0;
    int            m_ptr = 0;

    logic          ev, efd, eb, ec;
    logic [DW-1:0] ed;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_streaming = 0; m_in_done = 0; m_fd_pending = 0;
        m_pushed = 0; m_pushed_last = 0; m_ptr = 0;
        last_exp = '0;
        exp_q.delete();
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [DW-1:0] data);
        longint off;
        load_en = 1'b1; load_addr = addr; load_data = data;
        off = longint'(addr) - longint'(BASE);
        if (!m_streaming && !m_in_done && off >= 0 && off < NPIX) mem_model[int'(off)] = data;
        m_pushed = 0; m_pushed_last = 0;
        tick();
        load_en = 1'b0;
        m_in_done = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        if (!m_streaming && !m_in_done) begin
            m_streaming = 1; m_ptr = 0;
        end
        m_pushed = 0; m_pushed_last = 0;
        tick();
        start = 1'b0;
        m_in_done = 0;
    endtask

    task automatic drive_rd(input logic rd);
        rd_en = rd;
        m_pushed = 0; m_pushed_last = 0;
        if (rd && m_streaming && m_ptr < NPIX) begin
            exp_q.push_back(mem_model[m_ptr]);
            m_ptr++;
            m_pushed = 1;
            m_pushed_last = (m_ptr == NPIX);
        end
        tick();
        rd_en = 1'b0;
    endtask

    // Expected outputs for the cycle just sampled.
    task automatic next_exp(output logic o_v, output logic [DW-1:0] o_d,
                            output logic o_fd, output logic o_busy, output logic o_conv);
        o_fd = m_fd_pending;
        m_fd_pending = m_pushed_last;
        m_in_done = o_fd;
        if (o_fd) m_streaming = 0;
        o_v = m_pushed;
        if (o_v) begin
            o_d = exp_q.pop_front();
            last_exp = o_d;
        end else begin
            o_d = last_exp;
        end
        o_busy = m_streaming || o_fd;
        o_conv = m_streaming;
        m_pushed = 0; m_pushed_last = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        n_checks++; if (conv_en !== 1'b0) begin n_fail++; $display("FAIL reset_conv_en: got %b expected 0", conv_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        drive_rd(1'b1);
        next_exp(ev, ed, efd, eb, ec);
        n_checks++; if (data_valid !== ev) begin n_fail++; $display("FAIL idle_rd_ignored: got %b expected %b", data_valid, ev); end
    endtask

    task automatic test_full_frame();
        for (int i = 1; i < NPIX; i++) load_word(BASE + 32'(i), DW'(i));
        // Pixel 0 is written in the same cycle as start and must be read back.
        load_en = 1'b1; load_addr = BASE; load_data = '0; start = 1'b1;
        mem_model[0] = '0; m_streaming = 1; m_ptr = 0; m_pushed = 0; m_pushed_last = 0;
        tick();
        load_en = 1'b0; start = 1'b0;
        n_checks++; if (conv_en !== 1'b1) begin n_fail++; $display("FAIL full_start_conv_en: got %b expected 1", conv_en); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_start_busy: got %b expected 1", busy); end
        for (int i = 0; i < NPIX + 2; i++) begin
            drive_rd(i < NPIX);
            next_exp(ev, ed, efd, eb, ec);
            n_checks++; if (data_valid !== ev) begin n_fail++; $display("FAIL full_valid[%0d]: got %b expected %b", i, data_valid, ev); end
            n_checks++; if (data_out !== ed) begin n_fail++; $display("FAIL full_data[%0d]: got %h expected %h", i, data_out, ed); end
            n_checks++; if (frame_done !== efd) begin n_fail++; $display("FAIL full_frame_done[%0d]: got %b expected %b", i, frame_done, efd); end
            n_checks++; if (busy !== eb) begin n_fail++; $display("FAIL full_busy[%0d]: got %b expected %b", i, busy, eb); end
            n_checks++; if (conv_en !== ec) begin n_fail++; $display("FAIL full_conv_en[%0d]: got %b expected %b", i, conv_en, ec); end
        end
    endtask

    task automatic test_toggle();
        do_start();
        for (int i = 0; i < 2 * NPIX + 2; i++) begin
            drive_rd((i % 2) == 0 && i < 2 * NPIX);
            next_exp(ev, ed, efd, eb, ec);
            n_checks++; if (data_valid !== ev) begin n_fail++; $display("FAIL toggle_valid[%0d]: got %b expected %b", i, data_valid, ev); end
            n_checks++; if (data_out !== ed) begin n_fail++; $display("FAIL toggle_data[%0d]: got %h expected %h", i, data_out, ed); end
            n_checks++; if (frame_done !== efd) begin n_fail++; $display("FAIL toggle_frame_done[%0d]: got %b expected %b", i, frame_done, efd); end
            n_checks++; if (busy !== eb) begin n_fail++; $display("FAIL toggle_busy[%0d]: got %b expected %b", i, busy, eb); end
        end
    endtask

    task automatic test_illegal_writes();
        load_word(BASE - 32'd1, 24'hAAAAAA);
        load_word(BASE + 32'(NPIX), 24'h555555);
        do_start();
        load_word(BASE, 24'hABCDEF);
        for (int i = 0; i < NPIX + 2; i++) begin
            drive_rd(i < NPIX);
            next_exp(ev, ed, efd, eb, ec);
            n_checks++; if (data_valid !== ev) begin n_fail++; $display("FAIL illegal_valid[%0d]: got %b expected %b", i, data_valid, ev); end
            n_checks++; if (data_out !== ed) begin n_fail++; $display("FAIL illegal_data[%0d]: got %h expected %h", i, data_out, ed); end
            n_checks++; if (frame_done !== efd) begin n_fail++; $display("FAIL illegal_frame_done[%0d]: got %b expected %b", i, frame_done, efd); end
        end
    endtask

    task automatic test_overrun();
        int n_valid;
        n_valid = 0;
        do_start();
        for (int i = 0; i < NPIX + 4; i++) begin
            drive_rd(1'b1);
            next_exp(ev, ed, efd, eb, ec);
            if (data_valid === 1'b1) n_valid++;
            n_checks++; if (data_valid !== ev) begin n_fail++; $display("FAIL overrun_valid[%0d]: got %b expected %b", i, data_valid, ev); end
            n_checks++; if (data_out !== ed) begin n_fail++; $display("FAIL overrun_data[%0d]: got %h expected %h", i, data_out, ed); end
            n_checks++; if (frame_done !== efd) begin n_fail++; $display("FAIL overrun_frame_done[%0d]: got %b expected %b", i, frame_done, efd); end
            n_checks++; if (busy !== eb) begin n_fail++; $display("FAIL overrun_busy[%0d]: got %b expected %b", i, busy, eb); end
        end
        n_checks++; if (n_valid != NPIX) begin n_fail++; $display("FAIL overrun_count: got %0d expected %0d", n_valid, NPIX); end
    endtask

    task automatic test_back_to_back();
        do_start();
        for (int i = 0; i < NPIX + 2; i++) begin
            drive_rd(i < NPIX);
            next_exp(ev, ed, efd, eb, ec);
            n_checks++; if (data_valid !== ev) begin n_fail++; $display("FAIL replay_valid[%0d]: got %b expected %b", i, data_valid, ev); end
            n_checks++; if (data_out !== ed) begin n_fail++; $display("FAIL replay_data[%0d]: got %h expected %h", i, data_out, ed); end
            n_checks++; if (frame_done !== efd) begin n_fail++; $display("FAIL replay_frame_done[%0d]: got %b expected %b", i, frame_done, efd); end
        end
    endtask

    task automatic test_reset_midframe();
        do_start();
        for (int i = 0; i < 7; i++) begin
            drive_rd(1'b1);
            next_exp(ev, ed, efd, eb, ec);
            n_checks++; if (data_out !== ed) begin n_fail++; $display("FAIL abort_pre_data[%0d]: got %h expected %h", i, data_out, ed); end
        end
        rst = 1'b1; rd_en = 1'b1;
        tick();
        rst = 1'b0; rd_en = 1'b0;
        model_reset();
        n_checks++; if (conv_en !== 1'b0) begin n_fail++; $display("FAIL abort_conv_en: got %b expected 0", conv_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL abort_data_valid: got %b expected 0", data_valid); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL abort_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL abort_data_out: got %h expected 0", data_out); end
        for (int i = 0; i < 3; i++) begin
            drive_rd(1'b0);
            next_exp(ev, ed, efd, eb, ec);
            n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_pulse[%0d]: got %b expected 0", i, frame_done); end
        end
        do_start();
        for (int i = 0; i < NPIX + 2; i++) begin
            drive_rd(i < NPIX);
            next_exp(ev, ed, efd, eb, ec);
            n_checks++; if (data_valid !== ev) begin n_fail++; $display("FAIL restart_valid[%0d]: got %b expected %b", i, data_valid, ev); end
            n_checks++; if (data_out !== ed) begin n_fail++; $display("FAIL restart_data[%0d]: got %h expected %h", i, data_out, ed); end
            n_checks++; if (frame_done !== efd) begin n_fail++; $display("FAIL restart_frame_done[%0d]: got %b expected %b", i, frame_done, efd); end
            n_checks++; if (busy !== eb) begin n_fail++; $display("FAIL restart_busy[%0d]: got %b expected %b", i, busy, eb); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_toggle();
        test_illegal_writes();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
